branch_resolve_queue: RTL

In-order queue that tracks conditional branches between prediction at fetch and resolution at execute. On resolve it compares the actual outcome with the 2-bit saturating-counter prediction and writes the trained counter value back to the predictor table. On a mismatch it raises a one-cycle mispredict and discards all younger queued branches. It is the training and recovery end of the branch-predictor interface: the predictor produces counter state, and this block consumes it and returns the updates.

---
 rtl/branch_resolve_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// In-order branch queue between prediction and resolve: trains 2-bit counters and flushes on mispredict.
// Ports: push (fetch side), resolve (execute side), update/mispredict pulses, occupancy Count.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PushValid,
  input  logic [IDX_W-1:0]         PushIndex,
  input  logic [1:0]               PushCounter,
  output logic                     PushReady,
  input  logic                     ResolveValid,
  input  logic                     ResolveTaken,
  output logic                     ResolveReady,
  output logic                     UpdateValid,
  output logic [IDX_W-1:0]         UpdateIndex,
  output logic [1:0]               UpdateCounter,
  output logic                     Mispredict,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [IDX_W-1:0] idx_mem [DEPTH];
  logic [1:0]       ctr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             push_go;
  logic             res_go;
  logic             miss;
  logic [IDX_W-1:0] head_idx;
  logic [1:0]       head_ctr;
  logic [1:0]       trained;

  assign PushReady    = (Count < FULL);
  assign ResolveReady = (Count != '0);

  assign push_go  = PushValid && PushReady;
  assign res_go   = ResolveValid && ResolveReady;
  assign head_idx = idx_mem[rd_ptr];
  assign head_ctr = ctr_mem[rd_ptr];

  // Predicted direction is the counter MSB.
  assign miss = res_go && (ResolveTaken != head_ctr[1]);

  always_comb begin
    trained = head_ctr;
    if (ResolveTaken) begin
      if (head_ctr != 2'd3)
        trained = head_ctr + 2'd1;
    end else begin
      if (head_ctr != 2'd0)
        trained = head_ctr - 2'd1;
    end
  end

  // A push racing a mispredicting resolve is younger and is dropped.
  always_ff @(posedge clk) begin
    if (push_go && !miss) begin
      idx_mem[wr_ptr] <= PushIndex;
      ctr_mem[wr_ptr] <= PushCounter;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      Count         <= '0;
      UpdateValid   <= 1'b0;
      UpdateIndex   <= '0;
      UpdateCounter <= '0;
      Mispredict    <= 1'b0;
    end else begin
      UpdateValid <= res_go;
      Mispredict  <= miss;
      if (res_go) begin
        UpdateIndex   <= head_idx;
        UpdateCounter <= trained;
      end
      if (miss) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        Count  <= '0;
      end else begin
        if (push_go)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (res_go)
          rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push_go, res_go})
          2'b10:   Count <= Count + CNT_W'(1);
          2'b01:   Count <= Count - CNT_W'(1);
          default: Count <= Count;
        endcase
      end
    end
  end

endmodule
